spi_cpu_cpu_debug_scan_master: RTL and testbench

//  Host-side initiator for the CPU debug slave's virtual-JTAG interface. It turns one
//  {IR, DR} command into a full virtual scan: UIR, CDR, SDR x DR_W, UDR.
//  Its outputs feed the debug slave's vji_* nets in place of the SLD hub, for simulation
//  and on-chip self-test. The DR value shifted out by the slave is returned as a response.

---
 rtl/spi_cpu_cpu_debug_scan_master.sv | 152 +++++++++++++++
 tb/tb_spi_cpu_cpu_debug_scan_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cpu_cpu_debug_scan_master.sv
// spi_cpu_cpu_debug_scan_master: turns one {IR, DR} command into a virtual
// JTAG scan (UIR, CDR, SDR x DR_W, UDR) and returns the DR shifted out.
module spi_cpu_cpu_debug_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int DR_W    = 38,
    parameter int IR_W    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    output logic [DR_W-1:0] rsp_dr,
    output logic [IR_W-1:0] rsp_ir_out,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [IR_W-1:0] ir_in,
    input  logic [IR_W-1:0] ir_out,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_udr,
    output logic            jtag_state_rti
);
    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CW = (DR_W > 1) ? $clog2(DR_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        UIR,
        CDR,
        SDR,
        UDR
    } state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic [CW-1:0]   bit_cnt;
    logic [IR_W-1:0] ir_q;
    logic [DR_W-1:0] dr_q;
    logic [DR_W-1:0] cap;
    logic            wrap;
    logic            rise;
    logic            fall;

    assign wrap = (div == DW'(TCK_DIV - 1));
    assign rise = wrap & ~tck;
    assign fall = wrap & tck;

    // Outputs move only at a fall so the slave sees them stable at its rising tck.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            div            <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            ir_in          <= '0;
            rsp_valid      <= 1'b0;
            rsp_dr         <= '0;
            rsp_ir_out     <= '0;
            cmd_ready      <= 1'b0;
            jtag_state_rti <= 1'b1;
            bit_cnt        <= '0;
            ir_q           <= '0;
            dr_q           <= '0;
            cap            <= '0;
        end else begin
            rsp_valid <= 1'b0;
            div       <= wrap ? '0 : div + 1'b1;
            if (wrap) begin
                tck <= ~tck;
            end
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        ir_q      <= cmd_ir;
                        dr_q      <= cmd_dr;
                        cmd_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fall) begin
                        ir_in          <= ir_q;
                        vs_uir         <= 1'b1;
                        jtag_state_rti <= 1'b0;
                        state          <= UIR;
                    end
                end
                UIR: begin
                    if (rise) begin
                        rsp_ir_out <= ir_out;
                    end
                    if (fall) begin
                        vs_uir <= 1'b0;
                        vs_cdr <= 1'b1;
                        state  <= CDR;
                    end
                end
                CDR: begin
                    if (fall) begin
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        tdi     <= dr_q[0];
                        dr_q    <= dr_q >> 1;
                        bit_cnt <= '0;
                        state   <= SDR;
                    end
                end
                SDR: begin
                    // tdo enters at the top so the first captured bit ends at bit 0
                    if (rise) begin
                        cap <= {tdo, cap[DR_W-1:1]};
                    end
                    if (fall) begin
                        if (bit_cnt == CW'(DR_W - 1)) begin
                            vs_sdr <= 1'b0;
                            tdi    <= 1'b0;
                            vs_udr <= 1'b1;
                            state  <= UDR;
                        end else begin
                            tdi     <= dr_q[0];
                            dr_q    <= dr_q >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                UDR: begin
                    if (fall) begin
                        vs_udr         <= 1'b0;
                        jtag_state_rti <= 1'b1;
                        rsp_dr         <= cap;
                        rsp_valid      <= 1'b1;
                        cmd_ready      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cpu_cpu_debug_scan_master.sv
// tb_spi_cpu_cpu_debug_scan_master: directed scans against a loopback slave,
// with a transaction-level model compared on every clk.
module tb_spi_cpu_cpu_debug_scan_master;
    localparam int AW = 38;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          cmd_valid_a, cmd_ready_a, rsp_valid_a;
    logic          tck_a, tdi_a, tdo_a;
    logic [1:0]    cmd_ir_a, rsp_ir_out_a, ir_in_a, ir_out_a;
    logic [AW-1:0] cmd_dr_a, rsp_dr_a;
    logic          uir_a, cdr_a, sdr_a, udr_a, rti_a;

    logic          cmd_valid_b, cmd_ready_b, rsp_valid_b;
    logic          tck_b, tdi_b, tdo_b;
    logic [1:0]    cmd_ir_b, rsp_ir_out_b, ir_in_b, ir_out_b;
    logic [BW-1:0] cmd_dr_b, rsp_dr_b;
    logic          uir_b, cdr_b, sdr_b, udr_b, rti_b;

    spi_cpu_cpu_debug_scan_master dut_a (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_ir(cmd_ir_a), .cmd_dr(cmd_dr_a),
        .rsp_valid(rsp_valid_a), .rsp_dr(rsp_dr_a),
        .rsp_ir_out(rsp_ir_out_a),
        .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a),
        .ir_in(ir_in_a), .ir_out(ir_out_a),
        .vs_uir(uir_a), .vs_cdr(cdr_a),
        .vs_sdr(sdr_a), .vs_udr(udr_a),
        .jtag_state_rti(rti_a)
    );

    spi_cpu_cpu_debug_scan_master #(
        .TCK_DIV(1), .DR_W(BW), .IR_W(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
        .rsp_valid(rsp_valid_b), .rsp_dr(rsp_dr_b),
        .rsp_ir_out(rsp_ir_out_b),
        .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b),
        .ir_in(ir_in_b), .ir_out(ir_out_b),
        .vs_uir(uir_b), .vs_cdr(cdr_b),
        .vs_sdr(sdr_b), .vs_udr(udr_b),
        .jtag_state_rti(rti_b)
    );

    // Loopback slave: shifts right on rising tck while in SDR.
    logic [AW-1:0] sr_a, preset_val_a;
    logic          preset_a;
    always @(posedge tck_a or posedge preset_a) begin
        if (preset_a) sr_a <= preset_val_a;
        else if (sdr_a) sr_a <= {tdi_a, sr_a[AW-1:1]};
    end
    assign tdo_a = sr_a[0];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rst_applied = 1'b0;
    logic armed = 1'b0;

    always @(posedge clk) begin
        cyc++;
        rst_applied <= !reset_n;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model A: each scan returns what the slave held at its start.
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] slave_next_a, cur_dr_a;
    logic [1:0]    cur_ir_a, exp_iro_a;
    logic          busy_a, p_tck_a, p_rsp_a, tck_seen_a;
    logic [45:0]   p_out_a;
    int            k_a, acc_a, uir_cyc_a, idx_a;
    int            n_u, n_c, n_s, n_d;

    always @(negedge clk) begin : model_a
        logic [3:0]  st;
        logic [45:0] outs;
        st   = {uir_a, cdr_a, sdr_a, udr_a};
        outs = {st, tdi_a, ir_in_a, rti_a, rsp_dr_a};
        if (preset_a) slave_next_a = preset_val_a;
        if (rst_applied) begin
            armed      = 1'b1;
            busy_a     = 1'b0;
            tck_seen_a = 1'b0;
            exp_q.delete();
            chk("rst_strobes_a", st, 0);
            chk("rst_tck_a", tck_a, 0);
            chk("rst_tdi_a", tdi_a, 0);
            chk("rst_rti_a", rti_a, 1);
            chk("rst_ready_a", cmd_ready_a, 0);
            chk("rst_rsp_valid_a", rsp_valid_a, 0);
        end else if (armed) begin
            if (rsp_valid_a) begin
                chk("rsp_pulse_a", p_rsp_a, 0);
                if (exp_q.size() == 0)
                    chk("rsp_unexpected_a", rsp_valid_a, 0);
                else
                    chk("rsp_dr_a", rsp_dr_a, exp_q.pop_front());
                chk("rsp_ir_out_a", rsp_ir_out_a, exp_iro_a);
                chk("scan_len_a", cyc - uir_cyc_a, 164);
                chk("n_uir_a", n_u, 1);
                chk("n_cdr_a", n_c, 1);
                chk("n_sdr_a", n_s, 38);
                chk("n_udr_a", n_d, 1);
                busy_a = 1'b0;
            end
            chk("ready_a", cmd_ready_a, !busy_a);
            chk("strobe_excl_a", $countones(st) <= 1, 1);
            chk("rti_a", rti_a, st == 0);
            if (st != 0) chk("ir_in_a", ir_in_a, cur_ir_a);
            if (outs != p_out_a)
                chk("change_at_fall_a", {p_tck_a, tck_a}, 2'b10);
            if (tck_a != p_tck_a) begin
                if (tck_seen_a) chk("tck_half_a", k_a, 2);
                k_a        = 1;
                tck_seen_a = 1'b1;
            end else begin
                k_a++;
            end
            if (uir_a && !p_out_a[45]) begin
                uir_cyc_a = cyc;
                idx_a     = 0;
                n_u = 0; n_c = 0; n_s = 0; n_d = 0;
                chk("uir_lag_a",
                    (cyc - acc_a >= 1) && (cyc - acc_a <= 4), 1);
            end
            if (tck_a && !p_tck_a) begin
                n_u += int'(uir_a);
                n_c += int'(cdr_a);
                n_s += int'(sdr_a);
                n_d += int'(udr_a);
                if (uir_a) exp_iro_a = ir_out_a;
                if (sdr_a && idx_a < AW) begin
                    chk("tdi_a", tdi_a, cur_dr_a[idx_a]);
                    idx_a++;
                end
            end
            if (cmd_valid_a && cmd_ready_a && reset_n) begin
                busy_a   = 1'b1;
                cur_ir_a = cmd_ir_a;
                cur_dr_a = cmd_dr_a;
                acc_a    = cyc + 1;
                exp_q.push_back(slave_next_a);
                slave_next_a = cmd_dr_a;
            end
        end
        p_tck_a = tck_a;
        p_out_a = outs;
        p_rsp_a = rsp_valid_a;
    end

    // Model B: short scan, tck every clk, tdo tied high.
    logic          p_tck_b, busy_b, tck_seen_b;
    logic [3:0]    p_st_b, tdi_seen_b;
    logic [1:0]    iro_b;
    int            k_b, uir_cyc_b, idx_b;

    always @(negedge clk) begin : model_b
        logic [3:0] st;
        st = {uir_b, cdr_b, sdr_b, udr_b};
        if (rst_applied) begin
            busy_b     = 1'b0;
            tck_seen_b = 1'b0;
            chk("rst_strobes_b", st, 0);
            chk("rst_rti_b", rti_b, 1);
        end else if (armed) begin
            if (rsp_valid_b) begin
                chk("rsp_dr_b", rsp_dr_b, 4'hF);
                chk("rsp_ir_out_b", rsp_ir_out_b, iro_b);
                chk("tdi_seq_b", tdi_seen_b, 4'b1001);
                chk("scan_len_b", cyc - uir_cyc_b, 14);
                busy_b = 1'b0;
            end
            chk("ready_b", cmd_ready_b, !busy_b);
            chk("strobe_excl_b", $countones(st) <= 1, 1);
            chk("rti_b", rti_b, st == 0);
            if (tck_b != p_tck_b) begin
                if (tck_seen_b) chk("tck_half_b", k_b, 1);
                k_b        = 1;
                tck_seen_b = 1'b1;
            end else begin
                k_b++;
            end
            if (uir_b && !p_st_b[3]) begin
                uir_cyc_b = cyc;
                idx_b     = 0;
            end
            if (tck_b && !p_tck_b) begin
                if (uir_b) iro_b = ir_out_b;
                if (sdr_b && idx_b < BW) begin
                    tdi_seen_b[idx_b] = tdi_b;
                    idx_b++;
                end
            end
            if (cmd_valid_b && cmd_ready_b && reset_n) busy_b = 1'b1;
        end
        p_tck_b = tck_b;
        p_st_b  = st;
    end

    task automatic preset(input logic [AW-1:0] v);
        @(posedge clk);
        #1 preset_val_a = v;
        preset_a = 1'b1;
        @(negedge clk);
        #1 preset_a = 1'b0;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready_a && n < 400);
        if (!cmd_ready_a) chk("accept_timeout_a", cmd_ready_a, 1);
    endtask

    task automatic send_a(input logic [1:0] ir, input logic [AW-1:0] dr);
        @(posedge clk);
        #1 cmd_valid_a = 1'b1;
        cmd_ir_a = ir;
        cmd_dr_a = dr;
        wait_ready_a();
        @(posedge clk);
        #1 cmd_valid_a = 1'b0;
    endtask

    task automatic wait_rsp_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_a && n < 400);
        if (!rsp_valid_a) chk("rsp_timeout_a", rsp_valid_a, 1);
    endtask

    task automatic wait_sdr_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sdr_a && n < 400);
        if (!sdr_a) chk("sdr_timeout_a", sdr_a, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n      = 1'b0;
        cmd_valid_a  = 1'b0;
        cmd_ir_a     = '0;
        cmd_dr_a     = '0;
        ir_out_a     = 2'b01;
        cmd_valid_b  = 1'b0;
        cmd_ir_b     = '0;
        cmd_dr_b     = '0;
        ir_out_b     = 2'b10;
        tdo_b        = 1'b1;
        preset_a     = 1'b0;
        preset_val_a = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", cmd_ready_a, 1);

        // single scan through the loopback slave
        preset(38'h15_5555_5555);
        send_a(2'b01, 38'h2A_AAAA_AAAA);
        wait_rsp_a();
        chk("t2_rsp", rsp_dr_a, 38'h15_5555_5555);
        chk("t2_sr", sr_a, 38'h2A_AAAA_AAAA);
        chk("t2_ir_out", rsp_ir_out_a, 2'b01);

        // back-to-back with cmd_valid held
        ir_out_a = 2'b10;
        @(posedge clk);
        #1 cmd_valid_a = 1'b1;
        cmd_ir_a = 2'b10;
        cmd_dr_a = 38'h01_2345_6789;
        wait_ready_a();
        @(posedge clk);
        #1 cmd_ir_a = 2'b11;
        cmd_dr_a = 38'h3F_0F0F_0F0F;
        wait_rsp_a();
        chk("t4_rsp1", rsp_dr_a, 38'h2A_AAAA_AAAA);
        chk("t4_ready_at_rsp", cmd_ready_a, 1);
        @(posedge clk);
        #1 cmd_valid_a = 1'b0;
        wait_rsp_a();
        chk("t4_rsp2", rsp_dr_a, 38'h01_2345_6789);

        // command presented while busy is held off
        send_a(2'b00, 38'h00_DEAD_BEEF);
        wait_sdr_a();
        @(posedge clk);
        #1 cmd_valid_a = 1'b1;
        cmd_ir_a = 2'b01;
        cmd_dr_a = 38'h2B_CAFE_F00D;
        repeat (8) begin
            @(negedge clk);
            chk("t5_ready_busy", cmd_ready_a, 0);
        end
        wait_rsp_a();
        chk("t5_rsp3", rsp_dr_a, 38'h3F_0F0F_0F0F);
        chk("t5_sr_unchanged", sr_a, 38'h00_DEAD_BEEF);
        @(posedge clk);
        #1 cmd_valid_a = 1'b0;
        wait_rsp_a();
        chk("t5_rsp4", rsp_dr_a, 38'h00_DEAD_BEEF);
        chk("t5_sr4", sr_a, 38'h2B_CAFE_F00D);

        // reset in the middle of SDR
        send_a(2'b11, 38'h12_3456_789A);
        wait_sdr_a();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_ready_release", cmd_ready_a, 1);
        repeat (180) begin
            @(negedge clk);
            chk("t1_no_rsp", rsp_valid_a, 0);
        end
        ir_out_a = 2'b11;
        preset(38'h0A_5A5A_5A5A);
        send_a(2'b10, 38'h35_A5A5_A5A5);
        wait_rsp_a();
        chk("t1_recover_rsp", rsp_dr_a, 38'h0A_5A5A_5A5A);
        chk("t1_recover_ir", rsp_ir_out_a, 2'b11);

        // short configuration
        @(posedge clk);
        #1 cmd_valid_b = 1'b1;
        cmd_ir_b = 2'b11;
        cmd_dr_b = 4'b1001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready_b && n < 100);
        if (!cmd_ready_b) chk("accept_timeout_b", cmd_ready_b, 1);
        @(posedge clk);
        #1 cmd_valid_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_b && n < 100);
        if (!rsp_valid_b) chk("rsp_timeout_b", rsp_valid_b, 1);
        chk("t6_ir_out", rsp_ir_out_b, 2'b10);
        chk("t6_rsp", rsp_dr_b, 4'hF);
        repeat (4) @(negedge clk);
        chk("t6_ir_in_hold", ir_in_b, 2'b11);
        chk("ir_in_hold_a", ir_in_a, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
